// File: rtl/output_drain_queue.sv
// Collects N result words per systolic-array column into an N*N store, then drains them on request.
// Define DRAIN_TRANSPOSE_EN for row-major readout; the default build reads in column-major address order.
module output_drain_queue #(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    start_i,
  input  logic                    clear_i,
  input  logic [N*DATA_WIDTH-1:0] data_i,
  input  logic [N-1:0]            valid_i,
  input  logic [N-1:0]            last_i,
  input  logic                    read_en_i,
  input  logic                    read_reset_i,
  output logic [DATA_WIDTH-1:0]   read_data_o,
  output logic                    read_valid_o,
  output logic                    read_last_o,
  output logic                    drain_done_o,
  output logic                    overflow_o
);

  localparam int DEPTH = N * N;
  localparam int CW    = $clog2(N + 1);
  localparam int IW    = (N > 1) ? $clog2(N) : 1;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

  state_t                  state, state_next;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [CW-1:0]           count [N];
  logic [N-1:0]            closed;
  logic [IW-1:0]           rd_hi, rd_lo;
  logic                    rd_end;
  logic [AW-1:0]           rd_addr;
  logic                    start_pass, collect_en, read_fire, read_is_last;

  always_comb begin
    state_next = state;
    start_pass = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_i) begin
          state_next = COLLECT;
          start_pass = 1'b1;
        end
      end
      COLLECT: if (&closed) state_next = DONE;
      DONE:    state_next = DONE;
      default: state_next = IDLE;
    endcase
    if (clear_i) begin
      state_next = IDLE;
      start_pass = 1'b0;
    end
  end

  assign collect_en   = (state == COLLECT) && !clear_i;
  assign read_fire    = (state == DONE) && read_en_i && !read_reset_i && !rd_end && !clear_i;
  assign read_is_last = (rd_hi == IW'(N - 1)) && (rd_lo == IW'(N - 1));
  assign drain_done_o = (state == DONE);

  // Read index k is held as (hi, lo) = (k / N, k mod N) so neither ordering needs a divider.
  always_comb begin
`ifdef DRAIN_TRANSPOSE_EN
    rd_addr = AW'(32'(rd_lo) * N + 32'(rd_hi));
`else
    rd_addr = AW'(32'(rd_hi) * N + 32'(rd_lo));
`endif
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state      <= IDLE;
      closed     <= '0;
      overflow_o <= 1'b0;
      for (int unsigned a = 0; a < DEPTH; a++) mem[a] <= '0;
      for (int unsigned j = 0; j < N; j++) count[j] <= '0;
    end else begin
      state <= state_next;
      if (start_pass) begin
        closed     <= '0;
        overflow_o <= 1'b0;
        for (int unsigned a = 0; a < DEPTH; a++) mem[a] <= '0;
        for (int unsigned j = 0; j < N; j++) count[j] <= '0;
      end else if (collect_en) begin
        for (int unsigned j = 0; j < N; j++) begin
          if (valid_i[j]) begin
            if (closed[j]) begin
              overflow_o <= 1'b1;
            end else begin
              mem[AW'(j * N + 32'(count[j]))] <= data_i[j*DATA_WIDTH +: DATA_WIDTH];
              count[j] <= count[j] + CW'(1);
              if (last_i[j] || (count[j] == CW'(N - 1))) closed[j] <= 1'b1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      read_data_o  <= '0;
      read_valid_o <= 1'b0;
      read_last_o  <= 1'b0;
      rd_hi        <= '0;
      rd_lo        <= '0;
      rd_end       <= 1'b0;
    end else begin
      read_valid_o <= read_fire;
      read_last_o  <= read_fire && read_is_last;
      if (read_fire) read_data_o <= mem[rd_addr];
      if (clear_i || read_reset_i || start_pass) begin
        rd_hi  <= '0;
        rd_lo  <= '0;
        rd_end <= 1'b0;
      end else if (read_fire) begin
        if (read_is_last) begin
          rd_end <= 1'b1;
        end else if (rd_lo == IW'(N - 1)) begin
          rd_lo <= '0;
          rd_hi <= rd_hi + IW'(1);
        end else begin
          rd_lo <= rd_lo + IW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_output_drain_queue.sv
// Directed bench for output_drain_queue at N=4; expected readout order follows DRAIN_TRANSPOSE_EN.
module tb_output_drain_queue;

  localparam int N  = 4;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            start = 1'b0;
  logic            clear = 1'b0;
  logic [N*DW-1:0] data = '0;
  logic [N-1:0]    valid = '0;
  logic [N-1:0]    last = '0;
  logic            read_en = 1'b0;
  logic            read_reset = 1'b0;
  logic [DW-1:0]   read_data;
  logic            read_valid, read_last, drain_done, overflow;

  int errors = 0;
  int checks = 0;

  output_drain_queue #(.N(N), .DATA_WIDTH(DW)) dut (
    .clk_i(clk), .rstn_i(rstn), .start_i(start), .clear_i(clear),
    .data_i(data), .valid_i(valid), .last_i(last),
    .read_en_i(read_en), .read_reset_i(read_reset),
    .read_data_o(read_data), .read_valid_o(read_valid), .read_last_o(read_last),
    .drain_done_o(drain_done), .overflow_o(overflow)
  );

  always #5 clk = ~clk;

  // Value expected at readout index k; short2 models column 2 closed early after two words.
  function automatic logic [31:0] exp_word(int k, bit short2);
    int a, j, i;
`ifdef DRAIN_TRANSPOSE_EN
    a = (k % N) * N + k / N;
`else
    a = k;
`endif
    j = a / N;
    i = a % N;
    if (short2 && j == 2 && i >= 2) return 32'd0;
    return 32'(16 * j + i);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_col(int j, logic [31:0] v);
    data[j*DW +: DW] = v;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic load_full();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < N; i++) begin
      valid = '1;
      for (int j = 0; j < N; j++) set_col(j, 32'(16 * j + i));
      tick();
    end
    valid = '0;
    tick();
  endtask

  task automatic readout_check(bit short2);
    read_en = 1'b1;
    for (int k = 0; k < N * N; k++) begin
      tick();
      checks++;
      if ({read_valid, read_last, read_data} !== {1'b1, (k == N * N - 1), exp_word(k, short2)}) begin
        errors++;
        $display("FAIL read[%0d]: got valid=%b last=%b data=%0d, want valid=1 last=%b data=%0d",
                 k, read_valid, read_last, read_data, (k == N * N - 1), exp_word(k, short2));
      end
    end
    tick();
    checks++;
    if (read_valid !== 1'b0) begin
      errors++;
      $display("FAIL read_past_end: got read_valid=%b, want 0", read_valid);
    end
    read_en = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({read_valid, read_last, drain_done, overflow, read_data} !== {4'b0000, 32'd0}) begin
      errors++;
      $display("FAIL reset_outputs: got v/l/d/o=%b%b%b%b data=%0d, want 0000 data=0",
               read_valid, read_last, drain_done, overflow, read_data);
    end
    tick();
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_full_pass();
    do_clear();
    start = 1'b1;
    tick();
    start = 1'b0;
    read_en = 1'b1;
    for (int i = 0; i < N; i++) begin
      valid = '1;
      for (int j = 0; j < N; j++) set_col(j, 32'(16 * j + i));
      tick();
    end
    checks++;
    if ({drain_done, read_valid} !== 2'b00) begin
      errors++;
      $display("FAIL full_last_write: got drain_done=%b read_valid=%b, want 0 0", drain_done, read_valid);
    end
    valid = '0;
    read_en = 1'b0;
    tick();
    checks++;
    if ({drain_done, overflow} !== 2'b10) begin
      errors++;
      $display("FAIL full_done: got drain_done=%b overflow=%b, want 1 0", drain_done, overflow);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (drain_done !== 1'b1) begin
      errors++;
      $display("FAIL start_in_done: got drain_done=%b, want 1", drain_done);
    end
    readout_check(1'b0);
  endtask

  task automatic test_early_close();
    do_clear();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < N; i++) begin
      valid = (i < 2) ? 4'b1111 : 4'b1011;
      last  = (i == 1) ? 4'b0100 : 4'b0000;
      for (int j = 0; j < N; j++) set_col(j, 32'(16 * j + i));
      tick();
    end
    valid = '0;
    last  = '0;
    checks++;
    if (drain_done !== 1'b0) begin
      errors++;
      $display("FAIL early_pre_done: got drain_done=%b, want 0", drain_done);
    end
    tick();
    checks++;
    if ({drain_done, overflow} !== 2'b10) begin
      errors++;
      $display("FAIL early_done: got drain_done=%b overflow=%b, want 1 0", drain_done, overflow);
    end
    readout_check(1'b1);
  endtask

  task automatic test_overflow();
    int lo [N] = '{4, 0, 5, 5};
    int hi [N] = '{7, 4, 8, 8};
    do_clear();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 9; c++) begin
      valid = '0;
      for (int j = 0; j < N; j++) begin
        if (c >= lo[j] && c <= hi[j]) begin
          valid[j] = 1'b1;
          set_col(j, (j == 1 && c == 4) ? 32'hDEAD : 32'(16 * j + c - lo[j]));
        end
      end
      tick();
      if (c == 3) begin
        checks++;
        if (overflow !== 1'b0) begin
          errors++;
          $display("FAIL ovf_before: got overflow=%b, want 0", overflow);
        end
      end
      if (c == 4) begin
        checks++;
        if (overflow !== 1'b1) begin
          errors++;
          $display("FAIL ovf_set: got overflow=%b, want 1", overflow);
        end
      end
    end
    valid = '0;
    tick();
    checks++;
    if ({drain_done, overflow} !== 2'b11) begin
      errors++;
      $display("FAIL ovf_done: got drain_done=%b overflow=%b, want 1 1", drain_done, overflow);
    end
    readout_check(1'b0);
    do_clear();
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky_clear: got overflow=%b, want 1", overflow);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_start_clears: got overflow=%b, want 0", overflow);
    end
    do_clear();
  endtask

  task automatic test_idle();
    do_clear();
    start = 1'b1;
    clear = 1'b1;
    tick();
    start = 1'b0;
    clear = 1'b0;
    valid = '1;
    for (int i = 0; i < 5; i++) tick();
    valid = '0;
    tick();
    checks++;
    if ({drain_done, overflow} !== 2'b00) begin
      errors++;
      $display("FAIL idle_start_clear: got drain_done=%b overflow=%b, want 0 0", drain_done, overflow);
    end
    read_en = 1'b1;
    tick();
    tick();
    read_en = 1'b0;
    checks++;
    if (read_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_read: got read_valid=%b, want 0", read_valid);
    end
  endtask

  task automatic test_read_reset();
    do_clear();
    load_full();
    read_en = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    read_reset = 1'b1;
    tick();
    read_reset = 1'b0;
    checks++;
    if (read_valid !== 1'b0) begin
      errors++;
      $display("FAIL rewind_no_pulse: got read_valid=%b, want 0", read_valid);
    end
    tick();
    checks++;
    if ({read_valid, read_data} !== {1'b1, exp_word(0, 1'b0)}) begin
      errors++;
      $display("FAIL rewind_first: got valid=%b data=%0d, want 1 %0d", read_valid, read_data, exp_word(0, 1'b0));
    end
    tick();
    checks++;
    if ({read_valid, read_data} !== {1'b1, exp_word(1, 1'b0)}) begin
      errors++;
      $display("FAIL rewind_second: got valid=%b data=%0d, want 1 %0d", read_valid, read_data, exp_word(1, 1'b0));
    end
    read_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_clear();
    load_full();
    read_en = 1'b1;
    tick();
    tick();
    rstn = 1'b0;
    #1;
    checks++;
    if ({read_valid, read_last, drain_done, overflow, read_data} !== {4'b0000, 32'd0}) begin
      errors++;
      $display("FAIL reset_mid_read: got v/l/d/o=%b%b%b%b data=%0d, want 0000 data=0",
               read_valid, read_last, drain_done, overflow, read_data);
    end
    #2;
    rstn = 1'b1;
    tick();
    read_en = 1'b0;
    tick();
    checks++;
    if ({read_valid, drain_done} !== 2'b00) begin
      errors++;
      $display("FAIL reset_mid_read_after: got read_valid=%b drain_done=%b, want 0 0", read_valid, drain_done);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    valid = 4'b0010;
    for (int i = 0; i < 5; i++) tick();
    valid = '0;
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_pre_ovf: got overflow=%b, want 1", overflow);
    end
    rstn = 1'b0;
    #1;
    checks++;
    if ({read_valid, read_last, drain_done, overflow} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_mid_collect: got v/l/d/o=%b%b%b%b, want 0000", read_valid, read_last, drain_done, overflow);
    end
    #2;
    rstn = 1'b1;
    valid = '1;
    for (int i = 0; i < 4; i++) tick();
    valid = '0;
    tick();
    tick();
    checks++;
    if ({drain_done, read_valid, overflow} !== 3'b000) begin
      errors++;
      $display("FAIL reset_mid_after: got drain_done=%b read_valid=%b overflow=%b, want 0 0 0",
               drain_done, read_valid, overflow);
    end
  endtask

  initial begin
    test_reset();
    test_full_pass();
    test_early_close();
    test_overflow();
    test_idle();
    test_read_reset();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/output_drain_queue.md
OUTPUT_DRAIN_QUEUE -- requirements
Module: output_drain_queue

Interface
REQ-001 SHALL have parameter N, default 8, meaning systolic array dimension (N columns, N results per column).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning result word width.
REQ-003 SHALL have port clk_i  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rstn_i  input  1  asynchronous active-low reset.
REQ-005 SHALL have port start_i  input  1  begin a collection pass.
REQ-006 SHALL have port clear_i  input  1  abort or finish the pass and return to IDLE.
REQ-007 SHALL have port data_i  input  N x DATA_WIDTH  result word from each bottom-edge PE column.
REQ-008 SHALL have port valid_i  input  N  per-column result-valid strobe.
REQ-009 SHALL have port last_i  input  N  per-column final-result marker, qualified by valid_i.
REQ-010 SHALL have port read_en_i  input  1  request the next stored word.
REQ-011 SHALL have port read_reset_i  input  1  rewind the read pointer to 0.
REQ-012 SHALL have port read_data_o  output  DATA_WIDTH  registered readout word.
REQ-013 SHALL have port read_valid_o  output  1  one-cycle pulse qualifying read_data_o.
REQ-014 SHALL have port read_last_o  output  1  pulse with the final word (index N*N-1).
REQ-015 SHALL have port drain_done_o  output  1  level, high while in DONE.
REQ-016 SHALL have port overflow_o  output  1  sticky error flag.

Function
REQ-017 SHALL hold an N*N register-array store; column j occupies addresses j*N .. j*N+N-1.
REQ-018 SHALL implement states IDLE, COLLECT, DONE.
REQ-019 SHALL, in IDLE, move to COLLECT on start_i, zeroing all storage, all column counters and overflow_o in the same edge.
REQ-020 SHALL, in COLLECT, for each column j with valid_i[j] high and column j open, write data_i[j] to j*N+count[j] and increment count[j] (COUNT width $clog2(N+1)).
REQ-021 SHALL close column j when count[j] reaches N, or on the accepted word carrying last_i[j] (early close; remaining locations stay zero).
REQ-022 SHALL ignore valid_i[j] on a closed column and set overflow_o; accepted and rejected columns in the same cycle are handled independently.
REQ-023 SHALL move COLLECT -> DONE on the edge after the last column closes; drain_done_o rises that cycle.
REQ-024 SHALL ignore valid_i outside COLLECT without setting overflow_o.
REQ-025 SHALL, in DONE only, on read_en_i return the word at the read pointer on read_data_o with read_valid_o high on the next cycle (1-cycle latency) and advance the pointer.
REQ-026 SHALL assert read_last_o with the word at index N*N-1; further read_en_i SHALL be ignored (no pulse) until read_reset_i.
REQ-027 SHALL give read_reset_i priority over read_en_i in the same cycle; no read is produced.
REQ-028 SHALL ignore read_en_i in IDLE and COLLECT.
REQ-029 SHALL return to IDLE from any state on clear_i; clear_i beats start_i in the same cycle; the read pointer resets to 0; stored data is retained.
REQ-030 SHALL ignore start_i while in COLLECT or DONE.

Reset
REQ-031 SHALL, on rstn_i low, immediately enter IDLE, clear counters, read pointer and storage, and drive read_data_o=0, read_valid_o=0, read_last_o=0, drain_done_o=0, overflow_o=0.
REQ-032 SHALL, on reset mid-COLLECT or mid-readout, discard the pass; no pulse is emitted after rstn_i deasserts.

Configuration
REQ-033 SHALL, with macro DRAIN_TRANSPOSE_EN defined, read out in row-major order (index k maps to address (k mod N)*N + k/N); without it, read out in column-major address order 0..N*N-1.

Verification
REQ-034 N=4, start, each column receives 4 valid words value 16*j+i on consecutive cycles -> drain_done_o rises 1 cycle after the last write; 16 reads return 0,1,2,3,16,17,.. with read_last_o on the 16th; overflow_o=0.
REQ-035 N=4, column 2 gets 2 words with last_i on the second -> column closes; readout of addresses 10,11 returns 0; DONE reached once the others finish.
REQ-036 N=4, fifth valid_i[1] after column 1 is full -> storage unchanged, overflow_o=1 until next start_i.
REQ-037 N=4, start_i and clear_i together in IDLE -> stays IDLE; read_en_i in IDLE -> read_valid_o stays 0.
REQ-038 N=4, DRAIN_TRANSPOSE_EN defined, data as REQ-034 -> reads return 0,16,32,48,1,17,..; read_reset_i with read_en_i after 5 reads -> no pulse, next read returns 0.
REQ-039 rstn_i pulsed low mid-COLLECT -> all outputs 0 immediately; drain_done_o stays 0 after release.
